// File: rtl/ysyx_041461_axi_pkg.sv
// Shared AXI definitions for the data-side router.
// Holds the bus widths, the CLINT window defaults, the AXI response codes and
// the write/read FSM state encodings. There are no ports; other files import it.
package ysyx_041461_axi_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  // Default CLINT window: hit when (addr & MASK) == BASE.
  localparam logic [AXI_ADDR_W-1:0] CLINT_BASE_DFLT = 32'h0200_0000;
  localparam logic [AXI_ADDR_W-1:0] CLINT_MASK_DFLT = 32'hFFFF_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write path: idle/address, data beats, response.
  typedef enum logic [1:0] {
    WI = 2'd0,
    WD = 2'd1,
    WB = 2'd2
  } w_state_e;

  // Read path: idle/address, data beats.
  typedef enum logic {
    RI = 1'b0,
    RD = 1'b1
  } r_state_e;

endpackage

// File: rtl/ysyx_041461_axi_demux_if.sv
// One full AXI4 link (AW, W, B, AR, R).
// master modport: drives AW/W/AR payload+valid and B/R ready.
// slave modport : drives AW/W/AR ready and B/R payload+valid.
interface ysyx_041461_axi_demux_if
  import ysyx_041461_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W,
  parameter int unsigned ID_W   = AXI_ID_W
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic [DATA_W-1:0] rdata;
  logic              rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rid, rresp, rdata, rlast, output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rid, rresp, rdata, rlast, input rready
  );

endinterface

// File: rtl/ysyx_041461_axi_addr_dec.sv
// Address decoder: sel_c = 1 when addr falls in the CLINT window.
// Ports: addr (in, AXI_ADDR_W), sel_c (out, combinational).
module ysyx_041461_axi_addr_dec
  import ysyx_041461_axi_pkg::*;
#(
  parameter logic [AXI_ADDR_W-1:0] BASE = CLINT_BASE_DFLT,
  parameter logic [AXI_ADDR_W-1:0] MASK = CLINT_MASK_DFLT
) (
  input  logic [AXI_ADDR_W-1:0] addr,
  output logic                  sel_c
);

  assign sel_c = ((addr & MASK) == BASE);

endmodule

// File: rtl/ysyx_041461_axi_demux.sv
// 1-master to 2-slave AXI4 router. Slave 0 = main memory, slave 1 = CLINT.
// Ports: clk, rst (async, active-high); m (from core, slave modport);
//        s0 (to memory, master modport); s1 (to CLINT, master modport).
// Read and write paths each track one outstanding transaction. Handshakes
// pass straight through; only valid/ready are steered, payload is broadcast.
module ysyx_041461_axi_demux
  import ysyx_041461_axi_pkg::*;
#(
  parameter logic [AXI_ADDR_W-1:0] CLINT_BASE = CLINT_BASE_DFLT,
  parameter logic [AXI_ADDR_W-1:0] CLINT_MASK = CLINT_MASK_DFLT
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_041461_axi_demux_if.slave    m,
  ysyx_041461_axi_demux_if.master   s0,
  ysyx_041461_axi_demux_if.master   s1
);

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic     wsel_q, wsel_d;
  logic     rsel_q, rsel_d;

  logic aw_sel_c, ar_sel_c;
  logic wblk_c, rblk_c;

  logic                  aw_go_c, ar_go_c;
  logic                  s0_awvalid_c, s1_awvalid_c, m_awready_c;
  logic                  s0_wvalid_c, s1_wvalid_c, m_wready_c;
  logic                  m_bvalid_c, s0_bready_c, s1_bready_c;
  logic [AXI_ID_W-1:0]   m_bid_c;
  logic [1:0]            m_bresp_c;
  logic                  s0_arvalid_c, s1_arvalid_c, m_arready_c;
  logic                  m_rvalid_c, m_rlast_c, s0_rready_c, s1_rready_c;
  logic [AXI_ID_W-1:0]   m_rid_c;
  logic [1:0]            m_rresp_c;
  logic [AXI_DATA_W-1:0] m_rdata_c;

  // CLINT window decode for each address channel.
  ysyx_041461_axi_addr_dec #(.BASE(CLINT_BASE), .MASK(CLINT_MASK)) u_aw_dec (
    .addr  (m.awaddr),
    .sel_c (aw_sel_c)
  );

  ysyx_041461_axi_addr_dec #(.BASE(CLINT_BASE), .MASK(CLINT_MASK)) u_ar_dec (
    .addr  (m.araddr),
    .sel_c (ar_sel_c)
  );

  // CLINT interlock: a CLINT write waits for a CLINT read in flight; a CLINT
  // read waits for a CLINT write in flight or one being offered right now,
  // so a simultaneous pair resolves in favour of the write.
  assign wblk_c = aw_sel_c & (r_state_q == RD) & rsel_q;
  assign rblk_c = ar_sel_c & (((w_state_q != WI) & wsel_q) |
                              (m.awvalid & aw_sel_c & (w_state_q == WI)));

  // Payload broadcast to both slaves.
  assign s0.awid    = m.awid;     assign s1.awid    = m.awid;
  assign s0.awaddr  = m.awaddr;   assign s1.awaddr  = m.awaddr;
  assign s0.awlen   = m.awlen;    assign s1.awlen   = m.awlen;
  assign s0.awsize  = m.awsize;   assign s1.awsize  = m.awsize;
  assign s0.awburst = m.awburst;  assign s1.awburst = m.awburst;
  assign s0.wdata   = m.wdata;    assign s1.wdata   = m.wdata;
  assign s0.wstrb   = m.wstrb;    assign s1.wstrb   = m.wstrb;
  assign s0.wlast   = m.wlast;    assign s1.wlast   = m.wlast;
  assign s0.arid    = m.arid;     assign s1.arid    = m.arid;
  assign s0.araddr  = m.araddr;   assign s1.araddr  = m.araddr;
  assign s0.arlen   = m.arlen;    assign s1.arlen   = m.arlen;
  assign s0.arsize  = m.arsize;   assign s1.arsize  = m.arsize;
  assign s0.arburst = m.arburst;  assign s1.arburst = m.arburst;

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= WI;
      wsel_q    <= 1'b0;
      r_state_q <= RI;
      rsel_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wsel_q    <= wsel_d;
      r_state_q <= r_state_d;
      rsel_q    <= rsel_d;
    end
  end

  // Write FSM next state and write-path steering.
  always_comb begin : write_comb
    w_state_d    = w_state_q;
    wsel_d       = wsel_q;
    aw_go_c      = 1'b0;
    s0_awvalid_c = 1'b0;
    s1_awvalid_c = 1'b0;
    m_awready_c  = 1'b0;
    s0_wvalid_c  = 1'b0;
    s1_wvalid_c  = 1'b0;
    m_wready_c   = 1'b0;
    m_bvalid_c   = 1'b0;
    m_bid_c      = '0;
    m_bresp_c    = '0;
    s0_bready_c  = 1'b0;
    s1_bready_c  = 1'b0;
    unique case (w_state_q)
      WI: begin
        aw_go_c      = m.awvalid & ~wblk_c;
        s0_awvalid_c = aw_go_c & ~aw_sel_c;
        s1_awvalid_c = aw_go_c & aw_sel_c;
        m_awready_c  = (aw_sel_c ? s1.awready : s0.awready) & ~wblk_c;
        if (m.awvalid && m_awready_c) begin
          wsel_d    = aw_sel_c;
          w_state_d = WD;
        end
      end
      WD: begin
        s0_wvalid_c = m.wvalid & ~wsel_q;
        s1_wvalid_c = m.wvalid & wsel_q;
        m_wready_c  = wsel_q ? s1.wready : s0.wready;
        if (m.wvalid && m_wready_c && m.wlast) begin
          w_state_d = WB;
        end
      end
      WB: begin
        m_bvalid_c  = wsel_q ? s1.bvalid : s0.bvalid;
        m_bid_c     = wsel_q ? s1.bid    : s0.bid;
        m_bresp_c   = wsel_q ? s1.bresp  : s0.bresp;
        s0_bready_c = m.bready & ~wsel_q;
        s1_bready_c = m.bready & wsel_q;
        if (m_bvalid_c && m.bready) begin
          w_state_d = WI;
        end
      end
      default: w_state_d = WI;
    endcase
  end

  // Read FSM next state and read-path steering.
  always_comb begin : read_comb
    r_state_d    = r_state_q;
    rsel_d       = rsel_q;
    ar_go_c      = 1'b0;
    s0_arvalid_c = 1'b0;
    s1_arvalid_c = 1'b0;
    m_arready_c  = 1'b0;
    m_rvalid_c   = 1'b0;
    m_rid_c      = '0;
    m_rresp_c    = '0;
    m_rdata_c    = '0;
    m_rlast_c    = 1'b0;
    s0_rready_c  = 1'b0;
    s1_rready_c  = 1'b0;
    unique case (r_state_q)
      RI: begin
        ar_go_c      = m.arvalid & ~rblk_c;
        s0_arvalid_c = ar_go_c & ~ar_sel_c;
        s1_arvalid_c = ar_go_c & ar_sel_c;
        m_arready_c  = (ar_sel_c ? s1.arready : s0.arready) & ~rblk_c;
        if (m.arvalid && m_arready_c) begin
          rsel_d    = ar_sel_c;
          r_state_d = RD;
        end
      end
      RD: begin
        m_rvalid_c  = rsel_q ? s1.rvalid : s0.rvalid;
        m_rid_c     = rsel_q ? s1.rid    : s0.rid;
        m_rresp_c   = rsel_q ? s1.rresp  : s0.rresp;
        m_rdata_c   = rsel_q ? s1.rdata  : s0.rdata;
        m_rlast_c   = rsel_q ? s1.rlast  : s0.rlast;
        s0_rready_c = m.rready & ~rsel_q;
        s1_rready_c = m.rready & rsel_q;
        if (m_rvalid_c && m.rready && m_rlast_c) begin
          r_state_d = RI;
        end
      end
      default: r_state_d = RI;
    endcase
  end

  // Reset forces every valid/ready and master response field low at once,
  // independent of the clock.
  always_comb begin : out_gate
    s0.awvalid = s0_awvalid_c & ~rst;
    s1.awvalid = s1_awvalid_c & ~rst;
    m.awready  = m_awready_c  & ~rst;
    s0.wvalid  = s0_wvalid_c  & ~rst;
    s1.wvalid  = s1_wvalid_c  & ~rst;
    m.wready   = m_wready_c   & ~rst;
    m.bvalid   = m_bvalid_c   & ~rst;
    m.bid      = rst ? '0 : m_bid_c;
    m.bresp    = rst ? '0 : m_bresp_c;
    s0.bready  = s0_bready_c  & ~rst;
    s1.bready  = s1_bready_c  & ~rst;
    s0.arvalid = s0_arvalid_c & ~rst;
    s1.arvalid = s1_arvalid_c & ~rst;
    m.arready  = m_arready_c  & ~rst;
    m.rvalid   = m_rvalid_c   & ~rst;
    m.rid      = rst ? '0 : m_rid_c;
    m.rresp    = rst ? '0 : m_rresp_c;
    m.rdata    = rst ? '0 : m_rdata_c;
    m.rlast    = m_rlast_c    & ~rst;
    s0.rready  = s0_rready_c  & ~rst;
    s1.rready  = s1_rready_c  & ~rst;
  end

endmodule

// File: tb/tb_ysyx_041461_axi_demux.sv
// Bench for the AXI router: directed transactions; expected address routing
// and master-side responses are queued by the stimulus and checked by monitors.
module tb_ysyx_041461_axi_demux;
  import ysyx_041461_axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_041461_axi_demux_if m_if ();
  ysyx_041461_axi_demux_if s0_if ();
  ysyx_041461_axi_demux_if s1_if ();

  ysyx_041461_axi_demux dut (
    .clk (clk),
    .rst (rst),
    .m   (m_if),
    .s0  (s0_if),
    .s1  (s1_if)
  );

  typedef struct packed { logic sl; logic [31:0] addr; } a_exp_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [3:0] id; logic [63:0] data; logic last; logic [1:0] resp; } r_exp_t;

  a_exp_t aw_q[$];
  a_exp_t ar_q[$];
  b_exp_t b_q[$];
  r_exp_t r_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitors: pop and compare whenever a handshake is presented.
  a_exp_t ma;
  b_exp_t mb;
  r_exp_t mr;
  always @(negedge clk) begin
    if (!rst) begin
      if (s0_if.awvalid && s0_if.awready) begin
        if (aw_q.size() == 0) chk("aw_unexpected_s0", 1, 0);
        else begin ma = aw_q.pop_front(); chk("aw_slave", 0, 64'(ma.sl)); chk("aw_addr", s0_if.awaddr, ma.addr); end
      end
      if (s1_if.awvalid && s1_if.awready) begin
        if (aw_q.size() == 0) chk("aw_unexpected_s1", 1, 0);
        else begin ma = aw_q.pop_front(); chk("aw_slave", 1, 64'(ma.sl)); chk("aw_addr", s1_if.awaddr, ma.addr); end
      end
      if (s0_if.arvalid && s0_if.arready) begin
        if (ar_q.size() == 0) chk("ar_unexpected_s0", 1, 0);
        else begin ma = ar_q.pop_front(); chk("ar_slave", 0, 64'(ma.sl)); chk("ar_addr", s0_if.araddr, ma.addr); end
      end
      if (s1_if.arvalid && s1_if.arready) begin
        if (ar_q.size() == 0) chk("ar_unexpected_s1", 1, 0);
        else begin ma = ar_q.pop_front(); chk("ar_slave", 1, 64'(ma.sl)); chk("ar_addr", s1_if.araddr, ma.addr); end
      end
      if (m_if.bvalid && m_if.bready) begin
        if (b_q.size() == 0) chk("b_unexpected", 1, 0);
        else begin mb = b_q.pop_front(); chk("b_id", m_if.bid, mb.id); chk("b_resp", m_if.bresp, mb.resp); end
      end
      if (m_if.rvalid && m_if.rready) begin
        if (r_q.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          mr = r_q.pop_front();
          chk("r_id", m_if.rid, mr.id);
          chk("r_data", m_if.rdata, mr.data);
          chk("r_last", m_if.rlast, mr.last);
          chk("r_resp", m_if.rresp, mr.resp);
        end
      end
    end
  end

  task automatic init_sigs();
    m_if.awvalid = 0; m_if.awid = 0; m_if.awaddr = 0; m_if.awlen = 0; m_if.awsize = 3; m_if.awburst = 1;
    m_if.wvalid = 0; m_if.wdata = 0; m_if.wstrb = 0; m_if.wlast = 0; m_if.bready = 1;
    m_if.arvalid = 0; m_if.arid = 0; m_if.araddr = 0; m_if.arlen = 0; m_if.arsize = 3; m_if.arburst = 1;
    m_if.rready = 1;
    s0_if.awready = 1; s0_if.wready = 1; s0_if.arready = 1;
    s0_if.bvalid = 0; s0_if.bid = 0; s0_if.bresp = 0;
    s0_if.rvalid = 0; s0_if.rid = 0; s0_if.rresp = 0; s0_if.rdata = 0; s0_if.rlast = 0;
    s1_if.awready = 1; s1_if.wready = 1; s1_if.arready = 1;
    s1_if.bvalid = 0; s1_if.bid = 0; s1_if.bresp = 0;
    s1_if.rvalid = 0; s1_if.rid = 0; s1_if.rresp = 0; s1_if.rdata = 0; s1_if.rlast = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    m_if.awaddr = addr; m_if.awid = id; m_if.awlen = len; m_if.awvalid = 1;
  endtask

  task automatic set_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    m_if.araddr = addr; m_if.arid = id; m_if.arlen = len; m_if.arvalid = 1;
  endtask

  task automatic wait_awready();
    bit ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_if.awready) begin ok = 1; break; end
    end
    if (!ok) chk("aw_timeout", 0, 1);
    tick();
    m_if.awvalid = 0;
  endtask

  task automatic wait_arready();
    bit ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_if.arready) begin ok = 1; break; end
    end
    if (!ok) chk("ar_timeout", 0, 1);
    tick();
    m_if.arvalid = 0;
  endtask

  task automatic do_w(input logic [63:0] data, input logic last);
    bit ok = 0;
    m_if.wdata = data; m_if.wstrb = 8'hFF; m_if.wlast = last; m_if.wvalid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_if.wready) begin ok = 1; break; end
    end
    if (!ok) chk("w_timeout", 0, 1);
    tick();
    m_if.wvalid = 0; m_if.wlast = 0;
  endtask

  task automatic resp_b(input int idx, input logic [3:0] id, input logic [1:0] resp);
    bit ok = 0;
    if (idx == 0) begin s0_if.bvalid = 1; s0_if.bid = id; s0_if.bresp = resp; end
    else          begin s1_if.bvalid = 1; s1_if.bid = id; s1_if.bresp = resp; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_if.bvalid) begin ok = 1; break; end
    end
    if (!ok) chk("b_timeout", 0, 1);
    tick();
    s0_if.bvalid = 0; s1_if.bvalid = 0;
  endtask

  task automatic resp_r(input int idx, input logic [3:0] id, input logic [63:0] data,
                        input logic last, input logic [1:0] resp);
    bit ok = 0;
    if (idx == 0) begin s0_if.rvalid = 1; s0_if.rid = id; s0_if.rdata = data; s0_if.rlast = last; s0_if.rresp = resp; end
    else          begin s1_if.rvalid = 1; s1_if.rid = id; s1_if.rdata = data; s1_if.rlast = last; s1_if.rresp = resp; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_if.rvalid) begin ok = 1; break; end
    end
    if (!ok) chk("r_timeout", 0, 1);
    tick();
    s0_if.rvalid = 0; s0_if.rlast = 0; s1_if.rvalid = 0; s1_if.rlast = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: requests and stray slave responses present, all must be masked.
    init_sigs();
    set_aw(32'h8000_0000, 4'h1, 8'd0);
    set_ar(32'h8000_0000, 4'h1, 8'd0);
    m_if.wvalid = 1;
    s0_if.bvalid = 1; s0_if.bid = 4'h5; s0_if.rvalid = 1; s0_if.rdata = 64'hDEAD_BEEF; s0_if.rid = 4'h6;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s0_awvalid", s0_if.awvalid, 0);
    chk("rst_s0_arvalid", s0_if.arvalid, 0);
    chk("rst_s0_wvalid", s0_if.wvalid, 0);
    chk("rst_m_awready", m_if.awready, 0);
    chk("rst_m_arready", m_if.arready, 0);
    chk("rst_m_wready", m_if.wready, 0);
    chk("rst_m_bvalid", m_if.bvalid, 0);
    chk("rst_m_rvalid", m_if.rvalid, 0);
    chk("rst_m_rdata", m_if.rdata, 0);
    chk("rst_m_bid", m_if.bid, 0);
    chk("rst_m_rid", m_if.rid, 0);
    chk("rst_s0_bready", s0_if.bready, 0);
    chk("rst_s0_rready", s0_if.rready, 0);
    init_sigs();
    rst = 0;
    tick();

    // 1: CLINT single-beat write.
    aw_q.push_back('{sl: 1'b1, addr: 32'h0200_4000});
    set_aw(32'h0200_4000, 4'h3, 8'd0);
    wait_awready();
    m_if.wdata = 64'h10; m_if.wstrb = 8'hFF; m_if.wlast = 1; m_if.wvalid = 1;
    @(negedge clk);
    chk("t1_s1_wvalid", s1_if.wvalid, 1);
    chk("t1_s0_wvalid", s0_if.wvalid, 0);
    chk("t1_s1_wdata", s1_if.wdata, 64'h10);
    tick();
    m_if.wvalid = 0; m_if.wlast = 0;
    @(negedge clk);
    chk("t1_bvalid_before_s1", m_if.bvalid, 0);
    tick();
    b_q.push_back('{id: 4'h3, resp: RESP_EXOKAY});
    resp_b(1, 4'h3, RESP_EXOKAY);

    // 2: memory read, 4-beat burst.
    ar_q.push_back('{sl: 1'b0, addr: 32'h8000_0000});
    set_ar(32'h8000_0000, 4'h5, 8'd3);
    @(negedge clk);
    chk("t2_s1_arvalid", s1_if.arvalid, 0);
    chk("t2_s0_arvalid", s0_if.arvalid, 1);
    chk("t2_s0_arlen", s0_if.arlen, 3);
    tick();
    m_if.arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      r_q.push_back('{id: 4'h5, data: 64'h1000 + 64'(i), last: (i == 3), resp: RESP_OKAY});
      resp_r(0, 4'h5, 64'h1000 + 64'(i), (i == 3), RESP_OKAY);
    end
    s0_if.rvalid = 1; s0_if.rdata = 64'hBAD;
    @(negedge clk);
    chk("t2_idle_rvalid", m_if.rvalid, 0);
    chk("t2_idle_rdata", m_if.rdata, 0);
    chk("t2_idle_s0_rready", s0_if.rready, 0);
    tick();
    s0_if.rvalid = 0;

    // 3: AW and AR to CLINT in the same cycle; write wins.
    aw_q.push_back('{sl: 1'b1, addr: 32'h0200_4000});
    ar_q.push_back('{sl: 1'b1, addr: 32'h0200_BFF8});
    set_aw(32'h0200_4000, 4'h1, 8'd0);
    set_ar(32'h0200_BFF8, 4'h2, 8'd0);
    @(negedge clk);
    chk("t3_awready", m_if.awready, 1);
    chk("t3_arready_held", m_if.arready, 0);
    chk("t3_s1_arvalid_held", s1_if.arvalid, 0);
    tick();
    m_if.awvalid = 0;
    do_w(64'h22, 1'b1);
    @(negedge clk);
    chk("t3_arready_in_wb", m_if.arready, 0);
    tick();
    b_q.push_back('{id: 4'h1, resp: RESP_EXOKAY});
    resp_b(1, 4'h1, RESP_EXOKAY);
    wait_arready();
    r_q.push_back('{id: 4'h2, data: 64'h55, last: 1'b1, resp: RESP_EXOKAY});
    resp_r(1, 4'h2, 64'h55, 1'b1, RESP_EXOKAY);

    // 4: CLINT read outstanding; memory write flows, CLINT write stalls.
    ar_q.push_back('{sl: 1'b1, addr: 32'h0200_0008});
    set_ar(32'h0200_0008, 4'h4, 8'd0);
    wait_arready();
    aw_q.push_back('{sl: 1'b0, addr: 32'h8000_0010});
    set_aw(32'h8000_0010, 4'h6, 8'd0);
    @(negedge clk);
    chk("t4_mem_aw_nostall", m_if.awready, 1);
    tick();
    m_if.awvalid = 0;
    do_w(64'h66, 1'b1);
    b_q.push_back('{id: 4'h6, resp: RESP_OKAY});
    resp_b(0, 4'h6, RESP_OKAY);
    aw_q.push_back('{sl: 1'b1, addr: 32'h0200_4008});
    set_aw(32'h0200_4008, 4'h2, 8'd0);
    @(negedge clk);
    chk("t4_clint_aw_stall", m_if.awready, 0);
    chk("t4_s1_awvalid_stall", s1_if.awvalid, 0);
    tick();
    r_q.push_back('{id: 4'h4, data: 64'h0123_4567_89AB_CDEF, last: 1'b1, resp: RESP_EXOKAY});
    resp_r(1, 4'h4, 64'h0123_4567_89AB_CDEF, 1'b1, RESP_EXOKAY);
    wait_awready();
    do_w(64'h77, 1'b1);
    b_q.push_back('{id: 4'h2, resp: RESP_EXOKAY});
    resp_b(1, 4'h2, RESP_EXOKAY);

    // 5: reset in the middle of a memory write burst.
    aw_q.push_back('{sl: 1'b0, addr: 32'h8000_0100});
    set_aw(32'h8000_0100, 4'h7, 8'd3);
    wait_awready();
    m_if.wdata = 64'h88; m_if.wstrb = 8'hFF; m_if.wlast = 0; m_if.wvalid = 1;
    @(negedge clk);
    chk("t5_s0_wvalid_pre", s0_if.wvalid, 1);
    #1;
    rst = 1;
    set_aw(32'h8000_0300, 4'h9, 8'd0);
    #1;
    chk("t5_s0_wvalid_rst", s0_if.wvalid, 0);
    chk("t5_m_wready_rst", m_if.wready, 0);
    chk("t5_s0_awvalid_rst", s0_if.awvalid, 0);
    chk("t5_m_awready_rst", m_if.awready, 0);
    tick();
    m_if.awvalid = 0; m_if.wvalid = 0;
    rst = 0;
    tick();
    aw_q.push_back('{sl: 1'b0, addr: 32'h8000_0200});
    set_aw(32'h8000_0200, 4'h8, 8'd0);
    wait_awready();
    do_w(64'h99, 1'b1);
    b_q.push_back('{id: 4'h8, resp: RESP_OKAY});
    resp_b(0, 4'h8, RESP_OKAY);

    // 6: stray memory B while the write targets CLINT.
    aw_q.push_back('{sl: 1'b1, addr: 32'h0200_0000});
    set_aw(32'h0200_0000, 4'h9, 8'd0);
    wait_awready();
    do_w(64'hAA, 1'b1);
    s0_if.bvalid = 1; s0_if.bid = 4'hA; s0_if.bresp = RESP_SLVERR;
    @(negedge clk);
    chk("t6_stray_bvalid", m_if.bvalid, 0);
    chk("t6_stray_s0_bready", s0_if.bready, 0);
    tick();
    b_q.push_back('{id: 4'h9, resp: RESP_EXOKAY});
    s1_if.bvalid = 1; s1_if.bid = 4'h9; s1_if.bresp = RESP_EXOKAY;
    @(negedge clk);
    chk("t6_s0_bready_held", s0_if.bready, 0);
    chk("t6_s1_bready", s1_if.bready, 1);
    tick();
    s0_if.bvalid = 0; s1_if.bvalid = 0;
    repeat (2) tick();

    chk("aw_q_empty", 64'(aw_q.size()), 0);
    chk("ar_q_empty", 64'(ar_q.size()), 0);
    chk("b_q_empty", 64'(b_q.size()), 0);
    chk("r_q_empty", 64'(r_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
